// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator. All channels share one N-bit period
// counter; each has its own duty compare. Duty and period are double-buffered
// (shadow -> active) and only change at a period boundary, so outputs never glitch.
// Optional center-aligned counting is compiled in when PWM_CENTER_EN is defined;
// without it the mode input is ignored and the counter is always edge-aligned.
module pwm_multi #(
  parameter int N        = 8,
  parameter int CHANNELS = 4,
  parameter int AW       = $clog2(CHANNELS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                step,
  input  logic                mode,
  input  logic                cfg_wr,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [N-1:0]        cfg_data,
  output logic [CHANNELS-1:0] out,
  output logic                period_end,
  output logic                committed
);

  localparam logic [N-1:0]  MAX_VAL     = '1;
  localparam logic [AW-1:0] PERIOD_ADDR = AW'(CHANNELS);

  logic [N-1:0]        cnt_q, cnt_d;
  logic [N-1:0]        period_sh_q, period_sh_d;
  logic [N-1:0]        period_act_q, period_act_d;
  logic                dirty_q, dirty_d;
  logic [CHANNELS-1:0] out_q, out_d;
  logic                period_end_q, period_end_d;
  logic                committed_q, committed_d;
  logic                boundary;
  logic                commit;

  // A boundary with pending shadow writes copies every shadow to active at once
  assign commit       = boundary & dirty_q;
  assign period_end_d = boundary;
  assign committed_d  = commit;

`ifdef PWM_CENTER_EN
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  logic         dir_q, dir_d;
  logic [N-1:0] period_next;

  // Period that will be in force after this clock (new one if committing now)
  assign period_next = commit ? period_sh_q : period_act_q;
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  // Counter next state: advances only on ena & step, flags period boundaries
  always_comb begin
    cnt_d    = cnt_q;
    boundary = 1'b0;
`ifdef PWM_CENTER_EN
    dir_d    = dir_q;
`endif
    if (ena && step) begin
`ifdef PWM_CENTER_EN
      if (mode) begin
        if (dir_q == DIR_UP) begin
          if (period_act_q == '0) begin
            // Degenerate period: counter parks at 0 and every step is a boundary
            cnt_d    = '0;
            boundary = 1'b1;
          end else if (cnt_q == period_act_q) begin
            dir_d = DIR_DOWN;
            cnt_d = cnt_q - N'(1);
          end else begin
            cnt_d = cnt_q + N'(1);
          end
        end else begin
          if (cnt_q == '0) begin
            // Bottom of the triangle closes the period; restart upward with
            // whatever period takes effect here
            boundary = 1'b1;
            dir_d    = DIR_UP;
            cnt_d    = (period_next == '0) ? '0 : N'(1);
          end else begin
            cnt_d = cnt_q - N'(1);
          end
        end
      end else begin
`else
      begin
`endif
        if (cnt_q == period_act_q) begin
          cnt_d    = '0;
          boundary = 1'b1;
`ifdef PWM_CENTER_EN
          dir_d    = DIR_UP;
`endif
        end else begin
          cnt_d = cnt_q + N'(1);
        end
      end
    end
  end

  // Period shadow/active and the dirty flag; a write landing on a boundary
  // stays in shadow and keeps dirty set for the following boundary
  always_comb begin
    period_sh_d  = period_sh_q;
    period_act_d = period_act_q;
    dirty_d      = dirty_q;
    if (commit) begin
      period_act_d = period_sh_q;
      dirty_d      = 1'b0;
    end
    if (cfg_wr && (cfg_addr == PERIOD_ADDR)) begin
      period_sh_d = cfg_data;
    end
    if (cfg_wr && (cfg_addr <= PERIOD_ADDR)) begin
      dirty_d = 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [N-1:0] duty_sh_q, duty_sh_d;
      logic [N-1:0] duty_act_q, duty_act_d;
      logic         wr_hit;

      assign wr_hit = cfg_wr && (cfg_addr == AW'(gi));

      // Shadow takes writes; active picks up the pre-write shadow on commit
      always_comb begin
        duty_sh_d  = wr_hit ? cfg_data : duty_sh_q;
        duty_act_d = commit ? duty_sh_q : duty_act_q;
      end

      // Per-channel duty registers
      always_ff @(posedge clk) begin
        if (rst) begin
          duty_sh_q  <= '0;
          duty_act_q <= '0;
        end else begin
          duty_sh_q  <= duty_sh_d;
          duty_act_q <= duty_act_d;
        end
      end

      // Compare: duty above the period or all-ones saturates the output high
      assign out_d[gi] = ena & ((cnt_q < duty_act_q) |
                                (duty_act_q > period_act_q) |
                                (duty_act_q == MAX_VAL));
    end
  endgenerate

  // Shared state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      period_sh_q  <= MAX_VAL;
      period_act_q <= MAX_VAL;
      dirty_q      <= 1'b0;
      out_q        <= '0;
      period_end_q <= 1'b0;
      committed_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      period_sh_q  <= period_sh_d;
      period_act_q <= period_act_d;
      dirty_q      <= dirty_d;
      out_q        <= out_d;
      period_end_q <= period_end_d;
      committed_q  <= committed_d;
    end
  end

`ifdef PWM_CENTER_EN
  // Count direction for center-aligned mode
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q <= DIR_UP;
    end else begin
      dir_q <= dir_d;
    end
  end
`endif

  assign out        = out_q;
  assign period_end = period_end_q;
  assign committed  = committed_q;

endmodule
